pc_gen_unit: RTL and testbench

- Parametrised, clocked program-counter generator for the fetch stage; successor to the combinational PC+4 adder.
- Holds the architectural fetch PC and presents it to instruction memory with a valid/ready handshake.
- Advances by STEP on each accepted fetch.
- Applies prioritised redirects: exception > jump > branch.
- Counts accepted fetches for the performance/debug path.

---
 rtl/pc_gen_unit.sv | 139 +++++++++++++
 tb/tb_pc_gen_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator.
// Holds the fetch PC, offers it to instruction memory through a valid/ready
// handshake, advances by STEP on accept and applies prioritised redirects
// (exception > jump > branch). Also counts accepted fetches.
// Optional feature: define PC_MISALIGN_CHECK_EN to trap misaligned jump/branch
// targets to TRAP_VEC instead of silently masking their low bits.
module pc_gen_unit #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       STEP      = 4,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter logic [WIDTH-1:0]  TRAP_VEC  = WIDTH'(32'h0000_0080),
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_next_seq_o,
  output logic             pc_valid_o,
  input  logic             pc_ready_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             exc_i,
  output logic             redirected_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  // Bits below this mask must be zero for an aligned target.
  localparam logic [WIDTH-1:0] LowMask   = WIDTH'(STEP) - WIDTH'(1);
  localparam logic [WIDTH-1:0] AlignMask = ~LowMask;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             redirected_q, redirected_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             use_target;
  logic [WIDTH-1:0] target;

`ifdef PC_MISALIGN_CHECK_EN
  logic             misalign_q, misalign_d;
`endif

  assign accept        = pc_valid_q & pc_ready_i;
  assign pc_next_seq_o = pc_q + WIDTH'(STEP);

  // Jump beats branch when both are requested.
  assign use_target = jmp_i | br_taken_i;
  assign target     = jmp_i ? jmp_target_i : br_target_i;

  // Next-state selection: IDLE opens the request, RUN applies redirect priority.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    redirected_d = 1'b0;
    cnt_d        = cnt_q;
`ifdef PC_MISALIGN_CHECK_EN
    misalign_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // Redirects are ignored; first request goes out at RESET_VEC.
        state_d    = StRun;
        pc_valid_d = 1'b1;
      end
      StRun: begin
        pc_valid_d = 1'b1;
        // Old pc is consumed even when a redirect replaces it.
        cnt_d      = cnt_q + CNT_W'(accept);
        if (exc_i) begin
          pc_d         = TRAP_VEC;
          redirected_d = 1'b1;
        end else if (use_target) begin
          redirected_d = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
          if ((target & LowMask) != '0) begin
            pc_d       = TRAP_VEC;
            misalign_d = 1'b1;
          end else begin
            pc_d = target;
          end
`else
          pc_d = target & AlignMask;
`endif
        end else if (accept) begin
          pc_d = pc_next_seq_o;
        end
      end
      default: begin
        state_d    = StIdle;
        pc_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      pc_q         <= RESET_VEC;
      pc_valid_q   <= 1'b0;
      redirected_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      redirected_q <= redirected_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  // Misalign pulse register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign pc_o         = pc_q;
  assign pc_valid_o   = pc_valid_q;
  assign redirected_o = redirected_q;
  assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Table-driven bench for pc_gen_unit (WIDTH=32, STEP=4, RESET_VEC=0, TRAP_VEC=0x80).
module tb_pc_gen_unit;

`ifdef PC_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, pc_next_seq;
  logic        pc_valid, pc_ready;
  logic        br_taken, jmp, exc;
  logic [31:0] br_target, jmp_target;
  logic        redirected, misalign;
  logic [15:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  pc_gen_unit #(
    .WIDTH    (32),
    .STEP     (4),
    .RESET_VEC(32'h0),
    .TRAP_VEC (32'h80),
    .CNT_W    (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pc_o         (pc),
    .pc_next_seq_o(pc_next_seq),
    .pc_valid_o   (pc_valid),
    .pc_ready_i   (pc_ready),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .jmp_i        (jmp),
    .jmp_target_i (jmp_target),
    .exc_i        (exc),
    .redirected_o (redirected),
    .misalign_o   (misalign),
    .fetch_cnt_o  (fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        exc;
    logic        jmp;
    logic [31:0] jmp_t;
    logic        br;
    logic [31:0] br_t;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_redir;
    logic        e_mis;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rdy, logic e, logic j, logic [31:0] jt,
                              logic b, logic [31:0] bt, logic [31:0] epc, logic ev,
                              logic er, logic em, logic [15:0] ec);
    vec_t v;
    v.rst_n = r;   v.ready = rdy; v.exc = e;    v.jmp = j;     v.jmp_t = jt;
    v.br = b;      v.br_t = bt;   v.e_pc = epc; v.e_valid = ev; v.e_redir = er;
    v.e_mis = em;  v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%08h want 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive_and_check(input vec_t v, input int idx);
    rst_n      = v.rst_n;
    pc_ready   = v.ready;
    exc        = v.exc;
    jmp        = v.jmp;
    jmp_target = v.jmp_t;
    br_taken   = v.br;
    br_target  = v.br_t;
    @(posedge clk);
    #1;
    check("pc", idx, pc, v.e_pc);
    check("pc_valid", idx, 32'(pc_valid), 32'(v.e_valid));
    check("redirected", idx, 32'(redirected), 32'(v.e_redir));
    check("misalign", idx, 32'(misalign), 32'(v.e_mis));
    check("fetch_cnt", idx, 32'(fetch_cnt), 32'(v.e_cnt));
    check("pc_next_seq", idx, pc_next_seq, v.e_pc + 32'd4);
  endtask

  initial begin
    //                 rst rdy exc jmp jmp_t           br  br_t          pc              v  r  m   cnt
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,          0, 32'h0,     32'h0,          0, 0, 0, 16'd0)); // reset
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,          0, 32'h0,     32'h0,          1, 0, 0, 16'd0)); // IDLE->RUN
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,          0, 32'h0,     32'h4,          1, 0, 0, 16'd1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,          0, 32'h0,     32'h8,          1, 0, 0, 16'd2));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,          0, 32'h0,     32'hC,          1, 0, 0, 16'd3));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,          0, 32'h0,     32'h10,         1, 0, 0, 16'd4));
    // all three redirects with accept: exc wins, count still advances
    vecs.push_back(mk(1, 1, 1, 1, 32'h200,        1, 32'h300,   32'h80,         1, 1, 0, 16'd5));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,          0, 32'h0,     32'h80,         1, 0, 0, 16'd5));
    vecs.push_back(mk(1, 0, 0, 1, 32'hFFFF_FFFC,  0, 32'h0,     32'hFFFF_FFFC,  1, 1, 0, 16'd5));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,          0, 32'h0,     32'h0,          1, 0, 0, 16'd6)); // wrap
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,          1, 32'h103,
                      MisEn ? 32'h80 : 32'h100,                                 1, 1, MisEn, 16'd6));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,          0, 32'h0,
                      MisEn ? 32'h80 : 32'h100,                                 1, 0, 0, 16'd6));
    vecs.push_back(mk(1, 1, 0, 1, 32'h201,        0, 32'h0,
                      MisEn ? 32'h80 : 32'h200,                                 1, 1, MisEn, 16'd7));
    vecs.push_back(mk(1, 0, 0, 1, 32'h40,         1, 32'h500,   32'h40,         1, 1, 0, 16'd7)); // jmp>br
    vecs.push_back(mk(1, 0, 1, 1, 32'h203,        0, 32'h0,     32'h80,         1, 1, 0, 16'd7)); // exc>mis
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,          1, 32'h600,   32'h600,        1, 1, 0, 16'd8));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,          0, 32'h0,     32'h604,        1, 0, 0, 16'd9));
    // reset mid-run with stall and jump pending
    vecs.push_back(mk(0, 0, 0, 1, 32'h700,        0, 32'h0,     32'h0,          0, 0, 0, 16'd0));
    // jump in IDLE is ignored
    vecs.push_back(mk(1, 0, 0, 1, 32'h700,        0, 32'h0,     32'h0,          1, 0, 0, 16'd0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,          0, 32'h0,     32'h4,          1, 0, 0, 16'd1));

    rst_n = 1'b0; pc_ready = 1'b0; exc = 1'b0; jmp = 1'b0; br_taken = 1'b0;
    jmp_target = '0; br_target = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 6) begin
        // stall at pc=0x10: nothing moves for 4 cycles
        for (int k = 0; k < 4; k++) begin
          rst_n = 1'b1; pc_ready = 1'b0; exc = 1'b0; jmp = 1'b0; br_taken = 1'b0;
          @(posedge clk);
          #1;
          check("stall_pc", 100 + k, pc, 32'h10);
          check("stall_valid", 100 + k, 32'(pc_valid), 32'd1);
          check("stall_cnt", 100 + k, 32'(fetch_cnt), 32'd4);
        end
      end
      drive_and_check(vecs[i], i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
